// File: rtl/datapath_rr_arbiter.sv
// datapath_rr_arbiter
//   Round-robin arbiter that shares one datapath resource, such as a
//   register-file write port or a memory bus, among N_REQ requesters. The
//   resource is fed through a tree of 2:1 mux cells that is steered by `sel`.
//   The current owner keeps the grant until it signals `done` or drops its
//   request. The next owner is chosen by distance from the round-robin
//   pointer. There is no fixed priority.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, an owner may hold the grant for at most MAX_HOLD cycles.
//   It is then forced to release, and timeout_err pulses for one cycle.
//   When undefined, no hold counter is built and timeout_err is tied to 0.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   SEL_W    select width, equal to ceil(log2(N_REQ))
//   MAX_HOLD maximum hold cycles per grant (ARB_TIMEOUT_EN only)
//
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   req          per-requester request, held until its transaction completes
//   done         current owner finishes its transaction this cycle
//   grant        registered one-hot grant (or all zero)
//   sel          binary index of the current/last owner, drives mux selects
//   busy         high while a grant is asserted
//   timeout_err  one-cycle pulse on a forced release

module datapath_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout_err
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("datapath_rr_arbiter: N_REQ must be in 2..8");
  end
  if (SEL_W != $clog2(N_REQ)) begin : g_bad_sel_w
    $error("datapath_rr_arbiter: SEL_W must equal clog2(N_REQ)");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("datapath_rr_arbiter: MAX_HOLD must be at least 1");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             busy_nxt;

  logic             owner_req;
  logic             rel_normal;
  logic             force_rel;
  logic             rel;
  logic [SEL_W-1:0] after_owner;

  logic [SEL_W-1:0] scan_start;
  logic [N_REQ-1:0] scan_req;
  logic [N_REQ-1:0] rot;
  logic             scan_hit;
  logic [SEL_W:0]   scan_off;
  logic [SEL_W:0]   scan_sum;
  logic [SEL_W-1:0] scan_idx;

  // The owner is whoever holds the grant, so the owner's request bit can be
  // found by a mask and does not need an index into req.
  assign owner_req   = |(req & grant);
  assign rel_normal  = done | ~owner_req;
  assign rel         = rel_normal | force_rel;
  assign after_owner = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + SEL_W'(1);

  // One scanner serves both states. In IDLE it scans all of req starting at
  // ptr. In OWN it scans req with the owner masked off, starting just past
  // the owner, which is the pointer value being committed on release.
  assign scan_start = (state == IDLE) ? ptr : after_owner;
  assign scan_req   = (state == IDLE) ? req : (req & ~grant);

  // Rotate so that bit 0 is the scan start. The first set bit then gives the
  // distance from ptr, which is the only thing that breaks ties.
  assign rot = N_REQ'({scan_req, scan_req} >> scan_start);

  always_comb begin
    scan_hit = 1'b0;
    scan_off = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!scan_hit && rot[i]) begin
        scan_hit = 1'b1;
        scan_off = (SEL_W + 1)'(i);
      end
    end
  end

  // Wrap start+offset modulo N_REQ, so indices >= N_REQ never appear.
  assign scan_sum = {1'b0, scan_start} + scan_off;
  assign scan_idx = (scan_sum >= (SEL_W + 1)'(N_REQ))
                  ? (scan_sum[SEL_W-1:0] - SEL_W'(N_REQ))
                  : scan_sum[SEL_W-1:0];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    busy_nxt  = busy;
    if (state == IDLE) begin
      if (scan_hit) begin
        state_nxt = OWN;
        grant_nxt = N_REQ'(1) << scan_idx;
        sel_nxt   = scan_idx;
        busy_nxt  = 1'b1;
      end else begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    end else if (rel) begin
      ptr_nxt = after_owner;
      if (scan_hit) begin
        grant_nxt = N_REQ'(1) << scan_idx;
        sel_nxt   = scan_idx;
      end else if (owner_req && !force_rel) begin
        grant_nxt = grant;
      end else begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;

  // hold_cnt counts the finished OWN cycles without a release. The current
  // cycle is therefore number hold_cnt+1 of the hold. A done in the limit
  // cycle wins, and the release is then a normal one.
  assign force_rel = (state == OWN) && !rel_normal &&
                     (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_rel;
      hold_cnt    <= (state == OWN && !rel) ? hold_cnt + CNT_W'(1) : '0;
    end
  end
`else
  assign force_rel   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_rr_arbiter.sv
module tb_datapath_rr_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int MH = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          done = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [SW-1:0] sel;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner index (-1 when nobody owns), rotation
  // start, last select, cycles already held, and the pulse expected this cycle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_hold  = 0;
  bit m_terr  = 1'b0;

  datapath_rr_arbiter #(
    .N_REQ(N),
    .SEL_W(SW),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .done(done),
    .grant(grant),
    .sel(sel),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [N+SW+1:0] expv();
    logic [N-1:0] g;
    g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    return {g, SW'(m_sel), (m_owner >= 0), m_terr};
  endfunction

  task automatic model_update(input logic [N-1:0] r, input logic d, input logic rst);
    int  w;
    bit  normal, forced;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0; m_terr = 1'b0;
    end else if (m_owner < 0) begin
      m_terr = 1'b0;
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 0;
      end
    end else begin
      normal = d || !r[m_owner];
      forced = TMO && !normal && (m_hold + 1 == MH);
      m_terr = forced;
      if (normal || forced) begin
        m_ptr = (m_owner + 1) % N;
        w = pick(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_hold = 0;
        end else if (r[m_owner] && !forced) begin
          m_hold = 0;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic advance(input logic [N-1:0] r, input logic d, input logic rst);
    req = r; done = d; reset = rst;
    model_update(r, d, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      advance(N'($urandom), 1'($urandom), 1'b1);
      checks++;
      if ({grant, sel, busy, timeout_err} !== {N'(0), SW'(0), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset[%0d]: got g=%b s=%0d b=%b t=%b want all zero",
                 i, grant, sel, busy, timeout_err);
      end
    end
  endtask

  task automatic test_single();
    advance(4'b0100, 1'b0, 1'b0);
    checks++;
    if ({grant, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: got g=%b s=%0d b=%b want g=0100 s=2 b=1", grant, sel, busy);
    end
    for (int i = 0; i < 2; i++) begin
      advance(4'b0100, 1'b0, 1'b0);
      checks++;
      if ({grant, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
        errors++;
        $display("FAIL single_hold[%0d]: got g=%b s=%0d b=%b want g=0100 s=2 b=1", i, grant, sel, busy);
      end
    end
    advance(4'b0000, 1'b1, 1'b0);
    checks++;
    if ({grant, sel, busy} !== {4'b0000, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_release: got g=%b s=%0d b=%b want g=0000 s=2 b=0", grant, sel, busy);
    end
    advance(4'b0000, 1'b1, 1'b0);
    checks++;
    if ({grant, sel, busy} !== {4'b0000, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL idle_done_ignored: got g=%b s=%0d b=%b want g=0000 s=2 b=0", grant, sel, busy);
    end
  endtask

  task automatic test_rotation();
    advance(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      advance(4'b1111, (i > 0), 1'b0);
      checks++;
      if ({grant, sel, busy} !== {N'(1) << (i % N), SW'(i % N), 1'b1}) begin
        errors++;
        $display("FAIL rotation[%0d]: got g=%b s=%0d b=%b want g=%b s=%0d b=1",
                 i, grant, sel, busy, N'(1) << (i % N), i % N);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    advance(4'b0000, 1'b0, 1'b1);
    advance(4'b0001, 1'b0, 1'b0);
    advance(4'b0000, 1'b1, 1'b0);
    advance(4'b1001, 1'b0, 1'b0);
    checks++;
    if ({grant, sel} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("FAIL ptr_wrap_first: got g=%b s=%0d want g=1000 s=3", grant, sel);
    end
    advance(4'b1001, 1'b1, 1'b0);
    checks++;
    if ({grant, sel} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL ptr_wrap_second: got g=%b s=%0d want g=0001 s=0", grant, sel);
    end
  endtask

  task automatic test_abandon();
    advance(4'b0000, 1'b0, 1'b1);
    advance(4'b0010, 1'b0, 1'b0);
    advance(4'b0110, 1'b0, 1'b0);
    checks++;
    if ({grant, sel} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL abandon_hold: got g=%b s=%0d want g=0010 s=1", grant, sel);
    end
    advance(4'b0100, 1'b0, 1'b0);
    checks++;
    if ({grant, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL abandon_handoff: got g=%b s=%0d b=%b want g=0100 s=2 b=1", grant, sel, busy);
    end
  endtask

  task automatic test_reset_mid();
    advance(4'b0000, 1'b0, 1'b1);
    advance(4'b0010, 1'b0, 1'b0);
    advance(4'b0010, 1'b0, 1'b1);
    checks++;
    if ({grant, sel, busy} !== {4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got g=%b s=%0d b=%b want g=0000 s=0 b=0", grant, sel, busy);
    end
    advance(4'b0010, 1'b0, 1'b0);
    checks++;
    if ({grant, sel, busy} !== {4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL reset_regrant: got g=%b s=%0d b=%b want g=0010 s=1 b=1", grant, sel, busy);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      advance(4'b0000, 1'b0, 1'b1);
      advance(4'b0011, 1'b0, 1'b0);
      for (int k = 1; k < MH; k++) begin
        advance(4'b0011, 1'b0, 1'b0);
        checks++;
        if ({grant, timeout_err} !== {4'b0001, 1'b0}) begin
          errors++;
          $display("FAIL timeout_hold p%0d c%0d: got g=%b t=%b want g=0001 t=0",
                   pass, k, grant, timeout_err);
        end
      end
      advance(4'b0011, (pass == 1), 1'b0);
      checks++;
      if ({grant, timeout_err} !== {4'b0010, (pass == 0)}) begin
        errors++;
        $display("FAIL timeout_release p%0d: got g=%b t=%b want g=0010 t=%0d",
                 pass, grant, timeout_err, (pass == 0));
      end
      advance(4'b0011, 1'b0, 1'b0);
      checks++;
      if ({grant, timeout_err} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL timeout_pulse_end p%0d: got g=%b t=%b want g=0010 t=0",
                 pass, grant, timeout_err);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    logic         d, rst;
    r = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0) r = N'($urandom);
      d   = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 79) == 0);
      advance(r, d, rst);
      checks++;
      if ({grant, sel, busy, timeout_err} !== expv()) begin
        errors++;
        $display("FAIL random[%0d]: got {g,s,b,t}=%b want %b", i,
                 {grant, sel, busy, timeout_err}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_ptr_wrap();
    test_abandon();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_rr_arbiter.md
Name: datapath_rr_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource among N_REQ requesters, for example a register-file write port or a memory bus.
- The shared resource is fed through a mux tree built from 2:1 mux cells.
- The block drives the encoded mux select and a one-hot grant.
- Ownership is held across multi-cycle transactions until the owner signals done.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEL_W, 2, select width; must equal ceil(log2(N_REQ))
MAX_HOLD, 15, max cycles one owner may hold the grant (used only with the optional feature)

Ports:
clk  input  1  single system clock, rising-edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  request per requester; held high until granted transaction completes
done  input  1  current owner finishes its transaction this cycle
grant  output  N_REQ  one-hot grant, registered
sel  output  SEL_W  binary index of current/last owner; drives mux selects
busy  output  1  high while any grant is asserted
timeout_err  output  1  one-cycle pulse on forced release; tied 0 when feature is compiled out

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: grant=0, sel=0, busy=0, timeout_err=0, state=IDLE, round-robin pointer ptr=0, hold counter=0.
- Reset asserted mid-transaction: on that edge, all outputs and state go to reset values; the grant is dropped with no done required.
- States: IDLE and OWN.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, …, wrapping modulo N_REQ.
  - At the next edge: grant = onehot(winner), sel = winner, busy = 1, go to OWN. Latency from req to grant is 1 cycle.
  - If req == 0, stay in IDLE; grant = 0; sel holds its last value so the mux output stays stable.
- OWN, release condition: release = done | ~req[owner]. A dropped request counts as an abandon and is treated as done.
- OWN on release:
  - ptr = owner+1 mod N_REQ.
  - Re-arbitrate in the same cycle over req with the owner bit masked, scanning from owner+1.
  - If another request is pending, hand off at the next edge with no idle bubble.
  - Otherwise, if req[owner] is still high, re-grant to the owner.
  - Otherwise, go to IDLE: grant = 0, busy = 0.
- OWN without release: grant and sel are held unchanged.
- done asserted in IDLE is ignored.
- grant is always zero or one-hot, never multi-hot. sel always equals the index of the set grant bit whenever busy = 1.
- Invalid index (non-power-of-two N_REQ): sel values ≥ N_REQ are never generated.
- Simultaneous requests: the tie is broken purely by distance from ptr. There is no fixed priority.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter clears on each new grant and increments every OWN cycle without release.
  - When the counter reaches MAX_HOLD and release is not asserted, force a release. This follows the normal release path, including hand-off, but the owner is excluded from re-grant that cycle.
  - timeout_err pulses high for exactly one cycle, coincident with the grant change.
  - If done arrives in the same cycle the counter reaches MAX_HOLD, it is a normal release and timeout_err stays 0.
- Without the macro: no counter is built, timeout_err is constant 0, and ownership is unbounded.

Test Plan:
- Reset then req=4'b0100 → next cycle grant=0100, sel=2, busy=1. done pulse with req dropped → next cycle grant=0, busy=0, sel stays 2.
- Arbitration and rotation:
  - req=4'b1111 from reset → grant order 0001,0010,0100,1000,0001, advancing on each done pulse.
  - No IDLE bubble between grants; sel tracks 0,1,2,3,0.
- ptr=1 after owner 0 released; req=4'b1001 → grant=1000 (index 3 before wrap to 0). Then done → grant=0001.
- Owner 1 drops req without done while req[2]=1 → next cycle grant=0100, with no done required.
- With ARB_TIMEOUT_EN, MAX_HOLD=15:
  - Owner 0 holds with no done while req[1]=1 → after 15 OWN cycles grant=0010 and timeout_err=1 for exactly one cycle.
  - Repeat with done on cycle 15 → timeout_err stays 0.
- reset asserted while grant=0010 → next edge grant=0, sel=0, busy=0. After reset deasserts with req=4'b0010 → grant=0010 one cycle later.
